// File: rtl/game_timer_pkg.sv
// Shared game definitions: FSM state encodings, BCD limits and digit helpers.
// Pure definitions, no logic or latency of its own.
// No flow control; consumed by the game_timer block.
package game_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  // Largest legal BCD digit; loads above this are clamped to it.
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Two-digit BCD time value.
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_time_t;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

  function automatic logic bcd_is_zero(input bcd_time_t t);
    return (t.tens == 4'd0) && (t.ones == 4'd0);
  endfunction

  // One-second decrement; saturates at 00 so the display never wraps.
  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.ones != 4'd0) begin
      r.ones = t.ones - 4'd1;
    end else if (t.tens != 4'd0) begin
      r.ones = BCD_MAX;
      r.tens = t.tens - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/game_timer_if.sv
// Control/status bundle between a game controller and the game timer.
// Wires only, no latency.
// No backpressure: Start/Pause are single-cycle pulses, status is level.
interface game_timer_if;

  logic       Start;
  logic       Pause;
  logic [3:0] LoadTens;
  logic [3:0] LoadOnes;
  logic [3:0] TensDigit;
  logic [3:0] OnesDigit;
  logic       Running;
  logic       Expired;
  logic       TimeUp;

  // Controller side: issues commands, observes the countdown.
  modport master (
    output Start, Pause, LoadTens, LoadOnes,
    input  TensDigit, OnesDigit, Running, Expired, TimeUp
  );

  // Timer side: accepts commands, reports the countdown.
  modport slave (
    input  Start, Pause, LoadTens, LoadOnes,
    output TensDigit, OnesDigit, Running, Expired, TimeUp
  );

endinterface

// File: rtl/game_timer_second_tick.sv
// Clock divider: one-cycle Tick every CLOCK_FREQUENCY cycles while Run is high.
// Tick is combinational from the count; reload takes effect on the next edge.
// No backpressure; count freezes while Run is low so a partial second survives.
module second_tick #(
  parameter int CLOCK_FREQUENCY = 50000000
) (
  input  logic ClockIn,
  input  logic Reset,
  input  logic Run,
  input  logic Reload,
  output logic Tick
);

  localparam int CNT_W = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLOCK_FREQUENCY - 1);

  logic [CNT_W-1:0] count;

  // A reload in the same cycle suppresses the tick: a fresh load starts a full second.
  assign Tick = Run && !Reload && (count == '0);

  // Down-counter: reset/reload to max, decrement while running, wrap to max at zero.
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      count <= CNT_MAX;
    end else if (Reload) begin
      count <= CNT_MAX;
    end else if (Run) begin
      count <= (count == '0) ? CNT_MAX : count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/game_timer.sv
// Two-digit BCD countdown timer with start/pause control and expiry pulse.
// Digits update one edge after the internal tick; status outputs are registered.
// No backpressure: commands are accepted every cycle, Start over Pause over nothing.
module game_timer
  import game_timer_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000
) (
  input  logic          ClockIn,
  input  logic          Reset,
  game_timer_if.slave   bus
);

  state_t    state;
  state_t    state_nxt;
  bcd_time_t digits;
  bcd_time_t digits_nxt;
  bcd_time_t load_val;
  bcd_time_t dec_val;
  logic      tick;
  logic      time_up_nxt;
  logic      running_q;
  logic      expired_q;
  logic      time_up_q;

  assign load_val.tens = clamp_bcd(bus.LoadTens);
  assign load_val.ones = clamp_bcd(bus.LoadOnes);
  assign dec_val       = bcd_dec(digits);

  // The divider only advances in RUNNING; Start restarts the partial second.
  second_tick #(
    .CLOCK_FREQUENCY (CLOCK_FREQUENCY)
  ) u_second_tick (
    .ClockIn (ClockIn),
    .Reset   (Reset),
    .Run     (state == ST_RUNNING),
    .Reload  (bus.Start),
    .Tick    (tick)
  );

  // Next-state and next-digit decode: Start first, then tick, then Pause.
  always_comb begin
    state_nxt   = state;
    digits_nxt  = digits;
    time_up_nxt = 1'b0;
    if (bus.Start) begin
      digits_nxt  = load_val;
      state_nxt   = bcd_is_zero(load_val) ? ST_EXPIRED : ST_RUNNING;
      time_up_nxt = bcd_is_zero(load_val);
    end else begin
      case (state)
        ST_RUNNING: begin
          if (tick) begin
            digits_nxt = dec_val;
            if (bcd_is_zero(dec_val)) begin
              state_nxt   = ST_EXPIRED;
              time_up_nxt = 1'b1;
            end else if (bus.Pause) begin
              state_nxt = ST_PAUSED;
            end
          end else if (bus.Pause) begin
            state_nxt = ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (bus.Pause) begin
            state_nxt = ST_RUNNING;
          end
        end
        ST_EXPIRED: begin
          digits_nxt = '0;
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end
  end

  // State, digit and status registers; status decoded from the next state.
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state     <= ST_IDLE;
      digits    <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      time_up_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      digits    <= digits_nxt;
      running_q <= (state_nxt == ST_RUNNING);
      expired_q <= (state_nxt == ST_EXPIRED);
      time_up_q <= time_up_nxt;
    end
  end

  assign bus.TensDigit = digits.tens;
  assign bus.OnesDigit = digits.ones;
  assign bus.Running   = running_q;
  assign bus.Expired   = expired_q;
  assign bus.TimeUp    = time_up_q;

endmodule

// File: doc/game_timer.md
GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 50000000, clock cycles per game second.
REQ-002 SHALL have port ClockIn  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Start  input  1  single-cycle pulse; loads LoadTens/LoadOnes and runs.
REQ-005 SHALL have port Pause  input  1  single-cycle pulse; toggles RUNNING/PAUSED.
REQ-006 SHALL have port LoadTens  input  4  BCD tens digit of start time.
REQ-007 SHALL have port LoadOnes  input  4  BCD ones digit of start time.
REQ-008 SHALL have port TensDigit  output  4  current BCD tens digit, feeds HEX5 decoder.
REQ-009 SHALL have port OnesDigit  output  4  current BCD ones digit, feeds HEX4 decoder.
REQ-010 SHALL have port Running  output  1  high while state is RUNNING.
REQ-011 SHALL have port Expired  output  1  high while state is EXPIRED.
REQ-012 SHALL have port TimeUp  output  1  one-cycle pulse on entry to EXPIRED.

Function
REQ-013 SHALL implement FSM states IDLE, RUNNING, PAUSED, EXPIRED.
REQ-014 SHALL, on Start in any state, load digits (each value >9 clamped to 9), reload divider to CLOCK_FREQUENCY-1, and go to RUNNING, or to EXPIRED if the loaded value is 00.
REQ-015 SHALL give Start priority over Pause and over a same-cycle tick.
REQ-016 SHALL toggle RUNNING<->PAUSED on Pause; Pause in IDLE or EXPIRED is ignored.
REQ-017 SHALL run the divider only in RUNNING, counting CLOCK_FREQUENCY-1 down to 0, asserting an internal tick for one cycle at 0, then reloading.
REQ-018 SHALL hold the divider count in PAUSED, so resume continues the partial second.
REQ-019 SHALL, on tick, decrement BCD: ones>0 -> ones-1; ones=0 -> ones=9, tens-1.
REQ-020 SHALL update digits on the clock edge following the tick cycle (one-cycle latency).
REQ-021 SHALL, when a decrement yields 00, enter EXPIRED on that same edge and pulse TimeUp for exactly one cycle.
REQ-022 SHALL apply a tick coinciding with Pause first, then enter PAUSED.
REQ-023 SHALL hold digits at 00 in EXPIRED; digits never wrap below 00.
REQ-024 SHALL drive Running, Expired and TimeUp as registered outputs.

Reset
REQ-025 SHALL, on Reset, force state IDLE, TensDigit=0, OnesDigit=0, Running=0, Expired=0, TimeUp=0, divider=CLOCK_FREQUENCY-1.
REQ-026 SHALL give Reset priority over Start, Pause and tick, including mid-countdown.

Structure
REQ-027 SHALL take FSM state encodings and the BCD maximum digit (9) from the shared game package.
REQ-028 SHALL size the divider width from CLOCK_FREQUENCY with $clog2.
REQ-029 SHALL place the divider in one sub-module, second_tick, with ports ClockIn, Reset, Run, Reload, Tick.

Verification (CLOCK_FREQUENCY=4)
REQ-030 SHALL check: Start with load 1,2 -> Running=1; digits read 11 after 4 cycles and 10 after 8 cycles.
REQ-031 SHALL check: Start with load 1,0 -> first tick gives 0,9 (ones wraps 0->9, tens decrements).
REQ-032 SHALL check: Start with load 0,2 -> 01, then 00 with TimeUp high one cycle, Expired=1; further cycles keep 00.
REQ-033 SHALL check: load 0,5; Pause 2 cycles after Start, hold 10 cycles, Pause again -> digits frozen at 05, next decrement 2 cycles after resume.
REQ-034 SHALL check: Start with load 0,0 -> EXPIRED next edge, TimeUp pulse; Start with load 0xF,0xF -> digits 99.
REQ-035 SHALL check: Reset mid-countdown at 07 -> IDLE, digits 00, all status outputs 0; Start and Pause in the same cycle -> Start wins, Running=1.
